// File: rtl/ld_st_ctrl_pkg.sv
// Shared definitions for the load/store controller: transfer-flag bit
// indices, access-size encodings, FSM state encoding and the lane helpers
// used for store replication and load lane selection.
package ld_st_ctrl_pkg;

  // Bit positions inside transf_f
  localparam int P_I = 0;  // pre-index: access at the updated address
  localparam int U_I = 1;  // add offset (else subtract)
  localparam int W_I = 2;  // write updated address back to rn

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_BUS  = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Store data is replicated so every byte lane carries the value and the
  // memory picks the lane it needs from the address.
  function automatic logic [31:0] st_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;  // word and the reserved 2'b11 encoding
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of the read word and zero-extend it.
  function automatic logic [31:0] ld_lane(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: begin
        case (a)
          2'd0:    r = {24'd0, d[7:0]};
          2'd1:    r = {24'd0, d[15:8]};
          2'd2:    r = {24'd0, d[23:16]};
          default: r = {24'd0, d[31:24]};
        endcase
      end
      SZ_HALF: r = a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ldst_agu.sv
// Address generation for ld_st_ctrl: base +/- offset, pre/post-index select.
// Latency: combinational. Backpressure: none.
// Ports: i_rn_val/i_op2 base and offset, i_transf_f flags; o_addr access address, o_wb write-back value.
module ldst_agu
  import ld_st_ctrl_pkg::*;
(
  input  logic [31:0] i_rn_val,
  input  logic [31:0] i_op2,
  input  logic [4:0]  i_transf_f,
  output logic [31:0] o_addr,
  output logic [31:0] o_wb
);

  logic [31:0] w_eff;
  logic        w_unused_flags;

  assign w_eff  = i_transf_f[U_I] ? (i_rn_val + i_op2) : (i_rn_val - i_op2);
  // Post-indexed accesses use the unmodified base; the update still goes back.
  assign o_addr = i_transf_f[P_I] ? w_eff : i_rn_val;
  assign o_wb   = w_eff;

  // Only P/U matter here; W and the spare flag bits are consumed elsewhere.
  assign w_unused_flags = ^i_transf_f;

endmodule

// File: rtl/ld_st_ctrl.sv
// Load/store controller: one memory transfer per request, with base-register write-back.
// Latency: start->mem_req 2 edges, ack->done 1 edge; timeout after TIMEOUT_CYCLES BUS cycles.
// Backpressure: ready=0 while busy; start is ignored (not queued) until ready returns.
// Ports: clk, rst (async, active-high); request start/is_load/transf_f/size/rn_val/op2/rd_val;
//   memory mem_req/mem_we/mem_addr/mem_wdata/mem_size, mem_ack/mem_rdata;
//   status ready/done/fault; write-back rd_we/rd_data, rn_we/rn_data. All outputs registered.
// Optional: define LDST_ALIGN_CHECK_EN to fault misaligned half/word accesses in CALC.
module ld_st_ctrl
  import ld_st_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic [4:0]  transf_f,
  input  logic [1:0]  size,
  input  logic [31:0] rn_val,
  input  logic [31:0] op2,
  input  logic [31:0] rd_val,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic        rd_we,
  output logic        rn_we,
  output logic [31:0] rd_data,
  output logic [31:0] rn_data
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      r_state, w_nxt_state;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        r_is_load;
  logic [4:0]  r_flags;
  logic [1:0]  r_size;
  logic [31:0] r_rn, r_op2, r_rd, r_wb;
  logic [31:0] w_agu_addr, w_agu_wb;
  logic        w_misalign;

  ldst_agu u_agu (
    .i_rn_val   (r_rn),
    .i_op2      (r_op2),
    .i_transf_f (r_flags),
    .o_addr     (w_agu_addr),
    .o_wb       (w_agu_wb)
  );

`ifdef LDST_ALIGN_CHECK_EN
  // Size 2'b11 behaves as word, hence the test on size[1].
  assign w_misalign = ((r_size == SZ_HALF) && w_agu_addr[0]) ||
                      (r_size[1] && (w_agu_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_nxt   = 8'd0;  // counter is zero everywhere outside BUS
    case (r_state)
      ST_IDLE: if (start) w_nxt_state = ST_CALC;
      ST_CALC: w_nxt_state = w_misalign ? ST_ERR : ST_BUS;
      ST_BUS: begin
        // An ack arriving on the same edge the count expires still completes.
        if (mem_ack)                  w_nxt_state = ST_WB;
        else if (w_cnt_inc == TO_LIM) w_nxt_state = ST_ERR;
        else                          w_cnt_nxt   = w_cnt_inc;
      end
      ST_WB:   w_nxt_state = ST_IDLE;
      ST_ERR:  w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_is_load <= 1'b0;
      r_flags   <= 5'd0;
      r_size    <= 2'b00;
      r_rn      <= 32'd0;
      r_op2     <= 32'd0;
      r_rd      <= 32'd0;
      r_wb      <= 32'd0;
      ready     <= 1'b1;
      done      <= 1'b0;
      fault     <= 1'b0;
      rd_we     <= 1'b0;
      rn_we     <= 1'b0;
      rd_data   <= 32'd0;
      rn_data   <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_size  <= 2'b00;
    end else begin
      r_cnt   <= w_cnt_nxt;
      ready   <= (w_nxt_state == ST_IDLE);
      mem_req <= (w_nxt_state == ST_BUS);
      done    <= (w_nxt_state == ST_WB) || (w_nxt_state == ST_ERR);
      fault   <= (w_nxt_state == ST_ERR);
      rd_we   <= (w_nxt_state == ST_WB) && r_is_load;
      rn_we   <= (w_nxt_state == ST_WB) && r_flags[W_I];

      if ((r_state == ST_IDLE) && start) begin
        r_is_load <= is_load;
        r_flags   <= transf_f;
        r_size    <= size;
        r_rn      <= rn_val;
        r_op2     <= op2;
        r_rd      <= rd_val;
      end

      if (r_state == ST_CALC) r_wb <= w_agu_wb;

      // Bus fields are loaded once on BUS entry and held until exit.
      if ((r_state == ST_CALC) && (w_nxt_state == ST_BUS)) begin
        mem_addr  <= w_agu_addr;
        mem_we    <= ~r_is_load;
        mem_size  <= r_size;
        mem_wdata <= st_lanes(r_size, r_rd);
      end else if (w_nxt_state != ST_BUS) begin
        mem_addr  <= 32'd0;
        mem_we    <= 1'b0;
        mem_size  <= 2'b00;
        mem_wdata <= 32'd0;
      end

      if ((r_state == ST_BUS) && (w_nxt_state == ST_WB)) begin
        rn_data <= r_wb;
        if (r_is_load) rd_data <= ld_lane(mem_size, mem_addr[1:0], mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_ld_st_ctrl.sv
// Scoreboard bench for ld_st_ctrl (TIMEOUT_CYCLES=4).
// Latency: n/a. Backpressure: start is driven only when the bench expects acceptance.
module tb_ld_st_ctrl;
  import ld_st_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_load = 1'b0;
  logic [4:0]  transf_f = 5'd0;
  logic [1:0]  size = 2'b00;
  logic [31:0] rn_val = 32'd0, op2 = 32'd0, rd_val = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        ready, done, fault, rd_we, rn_we;
  logic [31:0] rd_data, rn_data;

  int total = 0, bad = 0, n_done = 0, n_exp_done = 0;

  typedef struct {
    logic        fault, rd_we, rn_we, we, nomem;
    logic [31:0] rd_data, rn_data, addr, wdata;
    logic [1:0]  sz;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  ld_st_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .transf_f(transf_f),
    .size(size), .rn_val(rn_val), .op2(op2), .rd_val(rd_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ready(ready), .done(done), .fault(fault), .rd_we(rd_we), .rn_we(rn_we),
    .rd_data(rd_data), .rn_data(rn_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] mkf(input bit p, input bit u, input bit w);
    logic [4:0] f;
    f = 5'd0;
    f[P_I] = p;
    f[U_I] = u;
    f[W_I] = w;
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after ready comes back.
  task automatic run_txn(input bit ld, input bit p, input bit u, input bit w,
                         input logic [1:0] sz, input logic [31:0] rn, input logic [31:0] o2,
                         input logic [31:0] rdv, input logic [31:0] rdat,
                         input int waits, input bit noack, input bit spam);
    exp_t e, ex;
    logic [31:0] eff, sh;
    int n;
    eff       = u ? rn + o2 : rn - o2;
    e.addr    = p ? eff : rn;
    e.rn_data = eff;
    e.we      = !ld;
    e.sz      = sz;
    case (sz)
      2'b00:   e.wdata = {rdv[7:0], rdv[7:0], rdv[7:0], rdv[7:0]};
      2'b01:   e.wdata = {rdv[15:0], rdv[15:0]};
      default: e.wdata = rdv;
    endcase
    sh = rdat >> (8 * int'(e.addr[1:0]));
    case (sz)
      2'b00:   e.rd_data = {24'd0, sh[7:0]};
      2'b01:   e.rd_data = e.addr[1] ? {16'd0, rdat[31:16]} : {16'd0, rdat[15:0]};
      default: e.rd_data = rdat;
    endcase
    e.nomem = 1'b0;
`ifdef LDST_ALIGN_CHECK_EN
    e.nomem = ((sz == 2'b01) && e.addr[0]) || (sz[1] && (e.addr[1:0] != 2'b00));
`endif
    e.fault = noack || e.nomem;
    e.rd_we = ld && !e.fault;
    e.rn_we = w && !e.fault;
    e.lat   = noack ? 4 : waits + 1;
    exp_q.push_back(e);
    n_exp_done++;

    start = 1'b1; is_load = ld; transf_f = mkf(p, u, w); size = sz;
    rn_val = rn; op2 = o2; rd_val = rdv;
    @(negedge clk);
    if (!spam) start = 1'b0;
    else begin  // keep requesting with different operands while busy
      is_load = !ld; rn_val = ~rn; op2 = o2 + 32'd1; rd_val = ~rdv;
    end
    chk("rdy_low", 32'(ready), 0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 20 && mem_req !== 1'b1 && done !== 1'b1);

    if (e.nomem) begin
      chk("misal_no_req", 32'(mem_req), 0);
      chk("misal_lat", 32'(n), 1);
    end else begin
      chk("req_lat", 32'(n), 1);
      chk("bus_addr", mem_addr, e.addr);
      chk("bus_wdata", mem_wdata, e.wdata);
      chk("bus_we", 32'(mem_we), 32'(e.we));
      chk("bus_size", 32'(mem_size), 32'(e.sz));
      mem_rdata = rdat;
      mem_ack   = !noack && (waits == 0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (done !== 1'b1) begin
          chk("addr_hold", mem_addr, e.addr);
          chk("wdata_hold", mem_wdata, e.wdata);
          chk("req_hold", 32'(mem_req), 1);
        end
        mem_ack = !noack && (n == waits);
      end while (n < 40 && done !== 1'b1);
      mem_ack = 1'b0;
      chk("done_lat", 32'(n), 32'(e.lat));
    end

    ex = exp_q.pop_front();
    chk("done", 32'(done), 1);
    chk("fault", 32'(fault), 32'(ex.fault));
    chk("rd_we", 32'(rd_we), 32'(ex.rd_we));
    chk("rn_we", 32'(rn_we), 32'(ex.rn_we));
    chk("req_off", 32'(mem_req), 0);
    if (ex.rd_we) chk("rd_data", rd_data, ex.rd_data);
    if (ex.rn_we) chk("rn_data", rn_data, ex.rn_data);
    start = 1'b0;

    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("fault_pulse", 32'(fault), 0);
    chk("rdwe_pulse", 32'(rd_we), 0);
    chk("rdy_back", 32'(ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int n, d0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rn_data", rn_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // ld p u w  size    rn            op2       rd_val        rdata         waits noack spam
    run_txn(1, 1, 1, 1, 2'b10, 32'h0000_1000, 32'd8,  32'd0,        32'hCAFE_F00D, 2, 0, 0);
    run_txn(0, 0, 0, 1, 2'b00, 32'h0000_2003, 32'd4,  32'h0000_00AB, 32'd0,        0, 0, 0);
    run_txn(1, 1, 1, 0, 2'b01, 32'h0000_0100, 32'd2,  32'd0,        32'hBEEF_1234, 1, 0, 0);
    run_txn(1, 0, 1, 0, 2'b00, 32'h0000_0301, 32'd5,  32'd0,        32'h1122_3344, 0, 0, 0);
    run_txn(0, 1, 0, 0, 2'b01, 32'h0000_0410, 32'd2,  32'h1234_5678, 32'd0,        0, 0, 0);
    run_txn(0, 1, 1, 1, 2'b11, 32'hFFFF_FFFC, 32'd8,  32'hDEAD_BEEF, 32'd0,        1, 0, 0);
    run_txn(1, 1, 1, 1, 2'b10, 32'h0000_5000, 32'd4,  32'd0,        32'h5555_AAAA, 0, 1, 0);
    // back-to-back after the timeout; ack on the final counted edge still completes
    run_txn(1, 1, 1, 1, 2'b10, 32'h0000_6000, 32'd12, 32'd0,        32'h0BAD_CAFE, 3, 0, 0);
    // start held high while busy must not launch a second transfer
    run_txn(1, 1, 1, 1, 2'b10, 32'h0000_7000, 32'd0,  32'd0,        32'h7777_0001, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_queue", 32'(mem_req), 0);
    end
    // word access at 0x1002: faults with the alignment check, issued as-is without
    run_txn(1, 1, 1, 0, 2'b10, 32'h0000_1000, 32'd2,  32'd0,        32'h0102_0304, 0, 0, 0);

    // reset in the middle of a bus wait
    start = 1'b1; is_load = 1'b1; transf_f = mkf(1, 1, 1); size = 2'b10;
    rn_val = 32'h0000_8000; op2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 20 && mem_req !== 1'b1);
    chk("pre_rst_req", 32'(mem_req), 1);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;  // stray ack while idle
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(n_done), 32'(d0));
    chk("rst_idle_req", 32'(mem_req), 0);

    run_txn(1, 1, 0, 1, 2'b00, 32'h0000_9004, 32'd1,  32'd0,        32'hA1B2_C3D4, 1, 0, 0);

    repeat (2) @(negedge clk);
    chk("done_total", 32'(n_done), 32'(n_exp_done));
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ld_st_ctrl.md
LD_ST_CTRL -- requirements
Module: ld_st_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUS-state cycles waited for mem_ack before fault (legal range 1..255).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  transfer request; sampled only when ready=1.
REQ-005 SHALL have port is_load  in  1  1=load, 0=store.
REQ-006 SHALL have port transf_f  in  5  transfer flags; bits P_I (pre-index), U_I (add offset), W_I (write back) from Defines.v are used.
REQ-007 SHALL have port size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
REQ-008 SHALL have ports rn_val, op2, rd_val  in  32 each  base register, offset, store data.
REQ-009 SHALL have ports mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_size  out  2  memory bus request.
REQ-010 SHALL have ports mem_ack  in  1; mem_rdata  in  32  memory bus response.
REQ-011 SHALL have ports ready, done, fault  out  1 each; rd_we, rn_we  out  1 each; rd_data, rn_data  out  32 each  status and register-file write-back.

Function
REQ-012 SHALL implement states IDLE, CALC, BUS, WB, ERR; all outputs registered.
REQ-013 IDLE: ready=1; start=1 at a clock edge latches all request inputs and goes to CALC; start while ready=0 is ignored with no queueing.
REQ-014 CALC (1 cycle): eff = U_I ? rn_val+op2 : rn_val-op2, mod 2^32; access address = P_I ? eff : rn_val; write-back value = eff; next state BUS.
REQ-015 BUS: mem_req=1, mem_addr/mem_we/mem_size/mem_wdata held stable until exit; mem_ack=1 at an edge goes to WB; mem_ack outside BUS is ignored.
REQ-016 Store data SHALL be replicated across lanes: byte -> 4 copies of rd_val[7:0], half -> 2 copies of rd_val[15:0], word -> rd_val.
REQ-017 Load data SHALL select the lane by mem_addr[1:0] (byte) or mem_addr[1] (half) and zero-extend into rd_data.
REQ-018 WB (1 cycle): done=1; rd_we=1 only for loads; rn_we=1 only if W_I; next state IDLE.
REQ-019 A wait counter SHALL clear on BUS entry, increment each BUS cycle without ack, and on reaching TIMEOUT_CYCLES go to ERR; an ack on that same edge wins, giving WB.
REQ-020 ERR (1 cycle): fault=1, done=1, rd_we=0, rn_we=0, mem_req=0; next state IDLE.
REQ-021 Zero-wait latency: start sampled at edge k, mem_req high after edge k+1, done high after edge k+2, ready high after edge k+3.
REQ-022 done, fault, rd_we, rn_we SHALL be single-cycle pulses.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, counter=0, ready=1 and every other output 0 (all 32-bit outputs 32'd0), including mid-BUS; no write-back is issued for the aborted transfer.

Configuration
REQ-024 With LDST_ALIGN_CHECK_EN defined, CALC SHALL route a half access with addr[0]=1 or a word access with addr[1:0]!=0 to ERR with no mem_req; without it, no check is made and the address is issued unmodified.

Structure
REQ-025 P_I/U_I/W_I indices, size encodings and state encodings SHALL live in the shared Defines.v.
REQ-026 Address/write-back arithmetic SHALL be one sub-module, ldst_agu (combinational: rn_val, op2, transf_f -> access address, write-back value).

Verification
REQ-027 Word load, P=1,U=1,W=1, rn=0x1000, op2=8, ack after 2 waits -> mem_addr=0x1008, rd_data=mem_rdata, rn_data=0x1008, done once.
REQ-028 Byte store, P=0,U=0,W=1, rn=0x2003, op2=4, rd_val=0xAB -> mem_addr=0x2003, mem_wdata=0xABABABAB, rn_data=0x1FFF, rd_we=0.
REQ-029 Half load at addr 0x102, mem_rdata=0xBEEF1234 -> rd_data=0x0000BEEF.
REQ-030 No ack, TIMEOUT_CYCLES=4 -> fault and done after 4 BUS cycles, no rd_we/rn_we; back-to-back start accepted next ready.
REQ-031 rst pulse mid-BUS -> mem_req=0 immediately, no done; LDST_ALIGN_CHECK_EN word at 0x1002 -> fault, mem_req never asserted.
